// File: rtl/ccff_chain_loader_pkg.sv
// Shared types, CRC constants and the serial CRC-16-CCITT step for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-feedback form: the incoming bit is folded into the bit leaving the top of the register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host word handshake between a configuration source (master) and the chain loader (slave).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              cfg_word_valid;
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_word_ready;

  modport master (output cfg_word_valid, output cfg_word, input cfg_word_ready);
  modport slave  (input cfg_word_valid, input cfg_word, output cfg_word_ready);
endinterface

// File: rtl/ccff_chain_loader_crc16.sv
// Serial CRC-16-CCITT register; clear has priority over en. crc_next exposes the value after this cycle's update.
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        prog_reset,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc,
  output logic [15:0] crc_next
);

  logic [15:0] crc_r;

  // next CRC value when a bit is folded in this cycle
  always_comb begin
    if (en) begin
      crc_next = crc16_step(crc_r, din);
    end else begin
      crc_next = crc_r;
    end
  end

  // CRC state register
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_r <= CRC_INIT;
    end else if (clear) begin
      crc_r <= CRC_INIT;
    end else begin
      crc_r <= crc_next;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host words LSB-first onto a scan configuration chain and gates its clock.
// Optional readback/CRC check pass is built when CCFF_LOADER_VERIFY_EN is defined.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             prog_clk,
  input  logic             prog_reset,
  input  logic             start,
  ccff_chain_loader_if.slave host,
  output logic             ccff_head,
  input  logic             ccff_tail,
  output logic             prog_clk_gate_en,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bit_count
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int SH_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(NWORDS + 1);

  state_e            state_r;
  logic [WORD_W-1:0] shreg_r;
  logic [SH_W-1:0]   sh_cnt_r;
  logic [WC_W-1:0]   word_cnt_r;
  logic              head_r;
  logic              ready_r;
  logic              gate_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [CNT_W-1:0]  bit_count_r;

  logic              accept_s;
  logic              last_bit_s;
  logic [SH_W-1:0]   word_bits_s;

`ifdef CCFF_LOADER_VERIFY_EN
  logic [15:0] crc_load_s;
  logic [15:0] crc_rb_next_s;
  logic [15:0] unused_crc_load_nx_s;
  logic [15:0] unused_crc_rb_s;
  logic        crc_clear_s;

  assign crc_clear_s = (state_r == ST_IDLE) && start;

  ccff_crc16 u_crc_load (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (crc_clear_s),
    .en         ((state_r == ST_LOAD) && gate_r),
    .din        (head_r),
    .crc        (crc_load_s),
    .crc_next   (unused_crc_load_nx_s)
  );

  ccff_crc16 u_crc_rb (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (crc_clear_s),
    .en         (state_r == ST_VERIFY),
    .din        (ccff_tail),
    .crc        (unused_crc_rb_s),
    .crc_next   (crc_rb_next_s)
  );

  // loopback is combinational so the chain ring stays exactly CHAIN_LEN long
  assign ccff_head = (state_r == ST_VERIFY) ? ccff_tail : head_r;
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
  assign ccff_head     = head_r;
`endif

  // handshake and word-size decode
  always_comb begin
    accept_s   = host.cfg_word_valid && ready_r;
    last_bit_s = gate_r && (bit_count_r == CNT_W'(CHAIN_LEN));
    if (word_cnt_r == WC_W'(NWORDS - 1)) begin
      word_bits_s = SH_W'(LAST_BITS);
    end else begin
      word_bits_s = SH_W'(WORD_W);
    end
  end

  // control FSM, shift register and registered outputs
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_r     <= ST_IDLE;
      shreg_r     <= '0;
      sh_cnt_r    <= '0;
      word_cnt_r  <= '0;
      head_r      <= 1'b0;
      ready_r     <= 1'b0;
      gate_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      bit_count_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          gate_r <= 1'b0;
          if (start) begin
            state_r     <= ST_LOAD;
            busy_r      <= 1'b1;
            ready_r     <= 1'b1;
            bit_count_r <= '0;
            word_cnt_r  <= '0;
            sh_cnt_r    <= '0;
            error_r     <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (last_bit_s) begin
            ready_r <= 1'b0;
`ifdef CCFF_LOADER_VERIFY_EN
            state_r     <= ST_VERIFY;
            bit_count_r <= CNT_W'(1);
`else
            state_r <= ST_DONE;
            gate_r  <= 1'b0;
            done_r  <= 1'b1;
`endif
          end else if (sh_cnt_r != SH_W'(0)) begin
            head_r      <= shreg_r[0];
            shreg_r     <= shreg_r >> 1;
            sh_cnt_r    <= sh_cnt_r - SH_W'(1);
            gate_r      <= 1'b1;
            bit_count_r <= bit_count_r + CNT_W'(1);
            ready_r     <= (sh_cnt_r == SH_W'(1)) && (word_cnt_r < WC_W'(NWORDS));
          end else if (accept_s) begin
            head_r      <= host.cfg_word[0];
            shreg_r     <= host.cfg_word >> 1;
            sh_cnt_r    <= word_bits_s - SH_W'(1);
            word_cnt_r  <= word_cnt_r + WC_W'(1);
            gate_r      <= 1'b1;
            bit_count_r <= bit_count_r + CNT_W'(1);
            ready_r     <= (word_bits_s == SH_W'(1)) &&
                           ((word_cnt_r + WC_W'(1)) < WC_W'(NWORDS));
          end else begin
            gate_r  <= 1'b0;
            ready_r <= (word_cnt_r < WC_W'(NWORDS));
          end
        end
`ifdef CCFF_LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (bit_count_r == CNT_W'(CHAIN_LEN)) begin
            state_r <= ST_DONE;
            gate_r  <= 1'b0;
            done_r  <= 1'b1;
            error_r <= (crc_load_s != crc_rb_next_s);
          end else begin
            bit_count_r <= bit_count_r + CNT_W'(1);
          end
        end
`endif
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          gate_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          gate_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign host.cfg_word_ready = ready_r;
  assign prog_clk_gate_en    = gate_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign error               = error_r;
  assign bit_count           = bit_count_r;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: vector table, corner sequences and random loads
// against a bit-stream model of the configuration chain.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 36;
  localparam int WORD_W    = 8;
  localparam int CNT_W     = 6;
`ifdef CCFF_LOADER_VERIFY_EN
  localparam int VER_CYC   = CHAIN_LEN;
`else
  localparam int VER_CYC   = 0;
`endif

  logic             prog_clk = 1'b0;
  logic             prog_reset;
  logic             start;
  logic             ccff_head;
  logic             ccff_tail;
  logic             gate;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] bit_count;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) host_if ();

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk         (prog_clk),
    .prog_reset       (prog_reset),
    .start            (start),
    .host             (host_if),
    .ccff_head        (ccff_head),
    .ccff_tail        (ccff_tail),
    .prog_clk_gate_en (gate),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .bit_count        (bit_count)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: gated shift register, optional stuck-at-1 on flop 17.
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] chain_nx;
  bit                   fault17 = 1'b0;
  assign chain_nx  = {chain[CHAIN_LEN-2:0], ccff_head} | (fault17 ? (36'd1 << 17) : 36'd0);
  assign ccff_tail = chain[CHAIN_LEN-1];
  always @(posedge prog_clk) if (gate) chain <= chain_nx;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // chain[35] holds the first bit shifted in, so reverse to get stream order
  function automatic logic [35:0] rev36(input logic [35:0] c);
    logic [35:0] r;
    for (int k = 0; k < 36; k++) r[k] = c[35-k];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_head"},  ccff_head, 0);
    check({tag, "_ready"}, host_if.cfg_word_ready, 0);
    check({tag, "_gate"},  gate, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_bitcnt"}, bit_count, 0);
  endtask

  // One full load from the current negedge (DUT idle). Stream bit i is words[i].
  task automatic run_load(input logic [39:0] words, input int stall_after, input int stall_len,
                          input bit rnd, input bit fault, input int busy_start_cyc,
                          output int done_cyc);
    logic [35:0] stream;
    int n, widx, stall_left, g, lows, last_gate, exp_bc;
    bit v, exp_err;
    stream     = words[35:0];
    widx       = 0;
    stall_left = stall_len;
    g          = 0;
    lows       = 0;
    last_gate  = -1;
    done_cyc   = -1;
`ifdef CCFF_LOADER_VERIFY_EN
    exp_err = fault;
`else
    exp_err = 1'b0;
`endif
    fault17 = fault;
    start = 1'b1;
    host_if.cfg_word_valid = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    n = 1;
    check("ready_cycle1", host_if.cfg_word_ready, 1);
    check("error_cleared", error, 0);
    while (n <= 250) begin
      if (gate) begin
        g++;
        last_gate = n;
      end
      check("busy", busy, 1);
      exp_bc = (g > CHAIN_LEN) ? g - CHAIN_LEN : g;
      check("bit_count", bit_count, exp_bc);
      if (gate && g <= CHAIN_LEN) check("head_bit", ccff_head, stream[g-1]);
      if (gate && g > CHAIN_LEN)  check("loopback", ccff_head, ccff_tail);
      if (!gate && g > 0 && g < CHAIN_LEN) begin
        lows++;
        check("head_hold", ccff_head, stream[g-1]);
      end
      if (host_if.cfg_word_ready) check("ready_word_limit", widx < 5, 1);
      if (done) begin
        done_cyc = n;
        break;
      end
      start = (n == busy_start_cyc);
      v = 1'b0;
      if (widx < 5) begin
        if (rnd) v = ($urandom_range(0, 2) != 0);
        else if (widx == stall_after && stall_left > 0 && host_if.cfg_word_ready) stall_left--;
        else v = 1'b1;
      end
      host_if.cfg_word_valid = v;
      host_if.cfg_word = (widx < 5) ? words[widx*8 +: 8] : 8'h00;
      if (v && host_if.cfg_word_ready) widx++;
      @(negedge prog_clk);
      n++;
    end
    start = 1'b0;
    host_if.cfg_word_valid = 1'b0;
    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 250 cycles, expected done");
    end else begin
      check("gate_total", g, CHAIN_LEN + VER_CYC);
      check("done_after_last_gate", done_cyc, last_gate + 1);
      if (!rnd) check("stall_cycles", lows, stall_len);
      check("error_at_done", error, exp_err);
      if (!fault) check("chain_contents", rev36(chain), stream);
      @(negedge prog_clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      check("error_sticky", error, exp_err);
    end
  endtask

  typedef struct {
    logic [39:0] words;
    int          stall_after;
    int          stall_len;
    logic [35:0] exp_stream;
    int          exp_done;
  } vec_t;

  initial begin
    vec_t        tbl [4];
    int          dc, n, widx;
    logic [39:0] rw;

    tbl[0] = '{40'h09_00_FF_3C_A5, 0, 0, 36'h9_00_FF_3C_A5, 38};
    tbl[1] = '{40'h09_00_FF_3C_A5, 2, 3, 36'h9_00_FF_3C_A5, 41};
    tbl[2] = '{40'hF5_78_56_34_12, 1, 1, 36'h5_78_56_34_12, 39};
    tbl[3] = '{40'hFF_FF_FF_FF_FF, 4, 5, 36'hF_FF_FF_FF_FF, 43};

    prog_reset = 1'b1;
    start = 1'b0;
    host_if.cfg_word_valid = 1'b0;
    host_if.cfg_word = 8'h00;
    repeat (3) @(negedge prog_clk);
    check_all_zero("reset");
    prog_reset = 1'b0;

    // host valid while idle is ignored
    host_if.cfg_word_valid = 1'b1;
    host_if.cfg_word = 8'hEE;
    @(negedge prog_clk);
    check("idle_ready", host_if.cfg_word_ready, 0);
    check("idle_busy", busy, 0);
    host_if.cfg_word_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_load(tbl[i].words, tbl[i].stall_after, tbl[i].stall_len, 1'b0, 1'b0, -1, dc);
      check("tbl_done_cycle", dc, tbl[i].exp_done + VER_CYC);
      check("tbl_chain", rev36(chain), tbl[i].exp_stream);
    end

    // start pulsed mid-load is ignored
    run_load(tbl[0].words, 0, 0, 1'b0, 1'b0, 5, dc);
    check("start_busy_done_cycle", dc, 38 + VER_CYC);

`ifdef CCFF_LOADER_VERIFY_EN
    run_load(tbl[0].words, 0, 0, 1'b0, 1'b1, -1, dc);
    check("fault_done_cycle", dc, 74);
    run_load(tbl[0].words, 0, 0, 1'b0, 1'b0, -1, dc);
    check("post_fault_chain", rev36(chain), tbl[0].exp_stream);
`endif

    // reset at bit 20 of a back-to-back load
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    n = 0;
    widx = 0;
    while (bit_count != CNT_W'(20) && n < 100) begin
      host_if.cfg_word_valid = (widx < 5);
      host_if.cfg_word = (widx < 5) ? tbl[0].words[widx*8 +: 8] : 8'h00;
      if (host_if.cfg_word_valid && host_if.cfg_word_ready) widx++;
      @(negedge prog_clk);
      n++;
    end
    check("reach_bit20", bit_count, 20);
    prog_reset = 1'b1;
    host_if.cfg_word_valid = 1'b0;
    @(negedge prog_clk);
    check_all_zero("midreset");
    prog_reset = 1'b0;
    run_load(tbl[0].words, 0, 0, 1'b0, 1'b0, -1, dc);
    check("reload_done_cycle", dc, 38 + VER_CYC);

    for (int r = 0; r < 6; r++) begin
      rw[31:0]  = $urandom;
      rw[39:32] = 8'($urandom);
      run_load(rw, 0, 0, 1'b1, 1'b0, -1, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
